btn_debouncer: RTL and testbench

//  Conditions N raw push-button inputs before the FND mode selector and other button consumers.

---
 rtl/btn_debouncer_pkg.sv | 22 ++
 rtl/btn_debouncer_if.sv | 13 +
 rtl/btn_debouncer_debounce_cell.sv | 130 +++++++++++++
 rtl/btn_debouncer.sv | 53 +++++
 tb/tb_btn_debouncer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/btn_debouncer_pkg.sv
// Shared types and helpers for the push-button debouncer.
// State encoding for the per-button FSM, ms-to-cycle conversion and counter sizing.
package btn_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Integer division first keeps the intermediate product inside 32 bits at 100 MHz.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debouncer_if.sv
// Button bundle between raw inputs and debounced consumers.
// master drives the raw buttons; slave (the debouncer) drives the conditioned outputs.
interface btn_debouncer_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;

  modport master (output btn_raw, input btn_level, input btn_rise, input btn_fall);
  modport slave  (input btn_raw, output btn_level, output btn_rise, output btn_fall);
endinterface

// File: rtl/btn_debouncer_debounce_cell.sv
// Single-button conditioner: 2-FF synchroniser, debounce FSM with stable-time counter,
// registered level/press/release outputs.
// Optional auto-repeat of the press pulse while held: build with BTN_REPEAT_EN defined.
//
//  state        | meaning
//  IDLE         | released and stable, level = 0
//  PRESS_WAIT   | input high, counting towards a confirmed press
//  PRESSED      | pressed and stable, level = 1
//  RELEASE_WAIT | input low, counting towards a confirmed release
module btn_debouncer_debounce_cell
  import btn_debouncer_pkg::*;
#(
  parameter int DB_CYCLES    = 4
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 10,
  parameter int REPEAT_RATE  = 3
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DB_CYCLES);
  // The transition fires on the edge that would have made cnt equal DB_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic s1, s2;
  btn_state_e state;
  logic [CW-1:0] cnt;

`ifdef BTN_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
  // Reloading to DELAY-RATE makes later pulses arrive every REPEAT_RATE cycles.
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);
  logic [RW-1:0] rep_cnt;
`endif

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce FSM: stable-time counting, registered level and one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
`ifdef BTN_REPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b1;
`ifdef BTN_REPEAT_EN
            rep_cnt <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s2) begin
            state <= RELEASE_WAIT;
            cnt   <= CW'(1);
`ifdef BTN_REPEAT_EN
            rep_cnt <= '0;
          end else if (rep_cnt == REP_LAST) begin
            rise    <= 1'b1;
            rep_cnt <= REP_RELOAD;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
`endif
          end
        end
        RELEASE_WAIT: begin
          if (s2) begin
            state <= PRESSED;
            cnt   <= '0;
`ifdef BTN_REPEAT_EN
            rep_cnt <= '0;
`endif
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_debouncer.sv
// N-button debouncer: one independent debounce cell per raw button input.
// Timing parameters are given in ms and converted to clk cycles here.
// BTN_REPEAT_EN: when defined, held buttons auto-repeat their press pulse.
module btn_debouncer
  import btn_debouncer_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_MS     = 10
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
`endif
) (
  input  logic clk,
  input  logic reset,
  btn_debouncer_if.slave btn
);

  localparam int DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
`ifdef BTN_REPEAT_EN
  localparam int REPEAT_DELAY = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
  localparam int REPEAT_RATE  = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);
`endif

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] rise_w;
  logic [N_BTN-1:0] fall_w;

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    btn_debouncer_debounce_cell #(
      .DB_CYCLES    (DB_CYCLES)
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .raw   (btn.btn_raw[i]),
      .level (level_w[i]),
      .rise  (rise_w[i]),
      .fall  (fall_w[i])
    );
  end

  assign btn.btn_level = level_w;
  assign btn.btn_rise  = rise_w;
  assign btn.btn_fall  = fall_w;

endmodule

// File: tb/tb_btn_debouncer.sv
// Bench for btn_debouncer: directed scenarios followed by random bouncing inputs,
// all checked every cycle against a window-based reference model.
module tb_btn_debouncer;

  localparam int N     = 4;
  localparam int DB    = 4;
  localparam int REP_D = 10;
  localparam int REP_R = 3;
`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  btn_debouncer_if #(.N_BTN(N)) bus ();

  btn_debouncer #(
    .N_BTN           (N),
    .CLK_HZ          (1000),
    .DEBOUNCE_MS     (4)
`ifdef BTN_REPEAT_EN
    ,
    .REPEAT_DELAY_MS (10),
    .REPEAT_RATE_MS  (3)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: hist[b][j] is the raw value sampled j edges ago; the logic sees it 2 edges late.
  int hist [N][6];
  bit m_lvl [N];
  int hold [N];
  logic [N-1:0] e_lvl, e_rise, e_fall;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < N; b++) begin
      for (int j = 0; j < 6; j++) hist[b][j] = 0;
      m_lvl[b] = 1'b0;
      hold[b]  = -1;
    end
    e_lvl  = '0;
    e_rise = '0;
    e_fall = '0;
  endfunction

  // A level flips once the last DB synchronised samples all disagree with it.
  function automatic void model_edge(input logic [N-1:0] r);
    for (int b = 0; b < N; b++) begin
      bit want;
      bit all_diff;
      for (int j = 5; j > 0; j--) hist[b][j] = hist[b][j-1];
      hist[b][0] = int'(r[b]);
      e_rise[b] = 1'b0;
      e_fall[b] = 1'b0;
      want = !m_lvl[b];
      all_diff = 1'b1;
      for (int j = 2; j < 2 + DB; j++) if (hist[b][j] != int'(want)) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl[b] = want;
        if (want) begin
          e_rise[b] = 1'b1;
          hold[b]   = 0;
        end else begin
          e_fall[b] = 1'b1;
          hold[b]   = -1;
        end
      end else if (m_lvl[b]) begin
        // hold = cycles spent continuously in the held state since (re)entering it.
        if (hist[b][2] == 0) hold[b] = -1;
        else if (hold[b] < 0) hold[b] = 0;
        else begin
          hold[b]++;
          if (REP_EN && hold[b] >= REP_D && (hold[b] - REP_D) % REP_R == 0) e_rise[b] = 1'b1;
        end
      end
      e_lvl[b] = m_lvl[b];
    end
  endfunction

  task automatic step(input logic [N-1:0] r, input string tag);
    bus.btn_raw = r;
    @(posedge clk);
    model_edge(r);
    #1;
    chk({tag, ".level"}, bus.btn_level, e_lvl);
    chk({tag, ".rise"},  bus.btn_rise,  e_rise);
    chk({tag, ".fall"},  bus.btn_fall,  e_fall);
    chk({tag, ".excl"},  bus.btn_rise & bus.btn_fall, 4'b0000);
  endtask

  task automatic do_reset(input string tag);
    #3 reset = 1'b1;
    #1;
    chk({tag, ".rst_level"}, bus.btn_level, 4'b0000);
    chk({tag, ".rst_rise"},  bus.btn_rise,  4'b0000);
    chk({tag, ".rst_fall"},  bus.btn_fall,  4'b0000);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] cur;
    logic [3:0] rep_count;
    int prob;

    bus.btn_raw = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.level", bus.btn_level, 4'b0000);
    chk("reset.rise",  bus.btn_rise,  4'b0000);
    chk("reset.fall",  bus.btn_fall,  4'b0000);
    #1 reset = 1'b0;

    // 1. Clean press on button 0: level and rise on the 6th sampling edge.
    for (int i = 1; i <= 10; i++) begin
      step(4'b0001, "t1");
      if (i == 5) chk("t1.level_early", {3'b000, bus.btn_level[0]}, 4'b0000);
      if (i == 6) chk("t1.level_on",    {3'b000, bus.btn_level[0]}, 4'b0001);
      if (i == 6) chk("t1.rise_pulse",  {3'b000, bus.btn_rise[0]},  4'b0001);
      if (i == 7) chk("t1.rise_end",    {3'b000, bus.btn_rise[0]},  4'b0000);
    end

    // 3. Release of button 0: single fall pulse.
    for (int i = 1; i <= 10; i++) begin
      step(4'b0000, "t3");
      if (i == 5) chk("t3.level_early", {3'b000, bus.btn_level[0]}, 4'b0001);
      if (i == 6) chk("t3.level_off",   {3'b000, bus.btn_level[0]}, 4'b0000);
      if (i == 6) chk("t3.fall_pulse",  {3'b000, bus.btn_fall[0]},  4'b0001);
      if (i == 7) chk("t3.fall_end",    {3'b000, bus.btn_fall[0]},  4'b0000);
    end

    // 2. Bounce on button 1: 3 high, 1 low, 3 high, then low -> nothing happens.
    for (int i = 0; i < 14; i++) begin
      step((i < 3 || (i >= 4 && i < 7)) ? 4'b0010 : 4'b0000, "t2");
      chk("t2.quiet", {1'b0, bus.btn_level[1], bus.btn_rise[1], bus.btn_fall[1]}, 4'b0000);
    end

    // 4. Simultaneous press of all buttons.
    for (int i = 1; i <= 8; i++) begin
      step(4'b1111, "t4");
      if (i == 6) chk("t4.rise_all", bus.btn_rise, 4'b1111);
      if (i == 7) chk("t4.rise_end", bus.btn_rise, 4'b0000);
    end
    for (int i = 0; i < 8; i++) step(4'b0000, "t4r");

    // 5. Reset in PRESS_WAIT with cnt=3, raw kept high through and after reset.
    for (int i = 0; i < 5; i++) step(4'b0001, "t5a");
    do_reset("t5");
    for (int i = 1; i <= 8; i++) begin
      step(4'b0001, "t5b");
      if (i == 1) chk("t5.no_exit_pulse", bus.btn_rise, 4'b0000);
      if (i == 5) chk("t5.level_early", {3'b000, bus.btn_level[0]}, 4'b0000);
      if (i == 6) chk("t5.rise_pulse",  {3'b000, bus.btn_rise[0]},  4'b0001);
    end
    for (int i = 0; i < 8; i++) step(4'b0000, "t5r");

    // 6. Hold button 2 for 20 cycles after the debounced press.
    for (int i = 0; i < 6; i++) step(4'b0100, "t6a");
    rep_count = 4'd0;
    for (int i = 1; i <= 20; i++) begin
      step(4'b0100, "t6b");
      if (bus.btn_rise[2]) rep_count = rep_count + 4'd1;
    end
    chk("t6.repeat_count", rep_count, REP_EN ? 4'd4 : 4'd0);
    for (int i = 0; i < 8; i++) step(4'b0000, "t6r");

    // Random bouncing: long holds first, then heavy chatter, with occasional resets.
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      prob = (c < 1500) ? 40 : 5;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, prob - 1) == 0) cur[b] = ~cur[b];
      step(cur, "rnd");
      if ($urandom_range(0, 399) == 0) do_reset("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
